// File: rtl/spi_master_pkg.sv
// ============================================================================
// Module   : spi_master_pkg
// Desc     : Shared state encoding and slave-select width helper for the
//            multi-slave SPI master.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        END   = 3'd4
    } state_e;

    // A single slave still needs a one-bit index port.
    function automatic int ss_width(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ============================================================================
// Module   : spi_clk_div
// Desc     : Half-period tick generator; counts 0..CLK_DIV-1 and pulses
//            tick_o on the terminal count, with a synchronous clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master_multi.sv
// ============================================================================
// Module   : spi_master_multi
// Desc     : SPI master serving NUM_SS slaves with valid/ready command port,
//            one-cycle response strobe and chip-select hold between words.
//            Optional macro SPI_MASTER_LOOPBACK_EN adds a loopback input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master_multi
    import spi_master_pkg::*;
#(
    parameter int   NUM_SS    = 2,
    parameter int   DATA_W    = 8,
    parameter int   CLK_DIV   = 4,
    parameter logic CPOL      = 1'b0,
    parameter logic CPHA      = 1'b0,
    parameter logic MSB_FIRST = 1'b1
) (
    input  logic                        clk_in_clk,
    input  logic                        reset_reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [DATA_W-1:0]           cmd_data,
    input  logic [ss_width(NUM_SS)-1:0] cmd_ss,
    input  logic                        cmd_last,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        spi_SCLK,
    output logic                        spi_MOSI,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                        loopback,
`endif
    input  logic                        spi_MISO,
    output logic [NUM_SS-1:0]           spi_SS_n
);

    localparam int                 SS_W      = ss_width(NUM_SS);
    localparam int                 EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0]  LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    state_e              state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                sclk_q;
    logic                mosi_q;
    logic [NUM_SS-1:0]   ss_n_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic [EDGE_W-1:0]   edge_q;
    logic                last_q;

    logic                w_accept;
    logic                w_tick;
    logic                w_clr;
    logic                w_lb;
    logic                w_miso;
    logic                w_drive;
    logic                w_sample;
    logic                w_first_bit;
    logic                w_head;
    logic [DATA_W-1:0]   w_data_shift;
    logic [DATA_W-1:0]   w_tx_load;
    logic [DATA_W-1:0]   w_tx_shift;
    logic [DATA_W-1:0]   w_rx_next;
    logic [NUM_SS-1:0]   w_ss_dec;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_lb = loopback;
`else
    assign w_lb = 1'b0;
`endif

    assign w_miso   = w_lb ? mosi_q : spi_MISO;
    assign w_accept = cmd_valid && cmd_ready_q;

    // Counter restarts on every accept; other state changes land on a wrap.
    assign w_clr = w_accept || (state_q == IDLE) || (state_q == HOLD);

    // edge_q counts completed SCLK edges, so bit 0 set means the next edge is even.
    assign w_drive  = CPHA ? ~edge_q[0] : (edge_q[0] && (edge_q != LAST_EDGE));
    assign w_sample = CPHA ?  edge_q[0] : ~edge_q[0];

    assign w_first_bit  = MSB_FIRST ? cmd_data[DATA_W-1] : cmd_data[0];
    assign w_data_shift = MSB_FIRST ? {cmd_data[DATA_W-2:0], 1'b0}
                                    : {1'b0, cmd_data[DATA_W-1:1]};
    assign w_tx_load    = CPHA ? cmd_data : w_data_shift;
    assign w_head       = MSB_FIRST ? tx_q[DATA_W-1] : tx_q[0];
    assign w_tx_shift   = MSB_FIRST ? {tx_q[DATA_W-2:0], 1'b0}
                                    : {1'b0, tx_q[DATA_W-1:1]};

    always_comb begin
        w_rx_next = rx_q;
        if (w_sample) begin
            w_rx_next = MSB_FIRST ? {rx_q[DATA_W-2:0], w_miso}
                                  : {w_miso, rx_q[DATA_W-1:1]};
        end
    end

    // Out-of-range indices match no line, leaving every select high.
    always_comb begin
        for (int i = 0; i < NUM_SS; i++) begin
            w_ss_dec[i] = w_lb || (cmd_ss != SS_W'(i));
        end
    end

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i  (clk_in_clk),
        .rst_ni (reset_reset_n),
        .clr_i  (w_clr),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk_in_clk) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            sclk_q      <= CPOL;
            mosi_q      <= 1'b0;
            ss_n_q      <= '1;
            tx_q        <= '0;
            rx_q        <= '0;
            edge_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    sclk_q      <= CPOL;
                    if (w_accept) begin
                        state_q <= SETUP;
                        ss_n_q  <= w_ss_dec;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 1'b1;
                        rx_q   <= w_rx_next;
                        if (w_drive) begin
                            mosi_q <= w_head;
                            tx_q   <= w_tx_shift;
                        end
                        if (edge_q == LAST_EDGE) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= w_rx_next;
                            edge_q      <= '0;
                            if (last_q) begin
                                state_q <= END;
                                ss_n_q  <= '1;
                            end else begin
                                state_q     <= HOLD;
                                cmd_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    sclk_q <= CPOL;
                    if (w_accept) begin
                        state_q <= SHIFT;
                    end
                end
                END: begin
                    if (w_tick) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Word capture is shared by IDLE and HOLD acceptance.
            if (w_accept) begin
                cmd_ready_q <= 1'b0;
                mosi_q      <= w_first_bit;
                tx_q        <= w_tx_load;
                rx_q        <= '0;
                edge_q      <= '0;
                last_q      <= cmd_last;
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign spi_SCLK  = sclk_q;
    assign spi_MOSI  = mosi_q;
    assign spi_SS_n  = ss_n_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_multi.sv
// ============================================================================
// Module   : tb_spi_master_multi
// Desc     : Directed bench for spi_master_multi: mode 0 / mode 3 instances
//            with simple slave models. SPI_MASTER_LOOPBACK_EN enables loopback.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_last = 1'b0;
    logic       sel = 1'b0;
    logic       lb = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [1:0] cmd_ss = 2'd0;

    logic       cmd_ready_a, rsp_valid_a, sclk_a, mosi_a;
    logic [7:0] rsp_data_a;
    logic [1:0] ss_n_a;
    logic       cmd_ready_b, rsp_valid_b, sclk_b, mosi_b;
    logic [7:0] rsp_data_b;
    logic [2:0] ss_n_b;

    logic       miso_a = 1'b0;
    logic       miso_b = 1'b0;
    logic       spi_miso_b;
    logic       cmd_valid_a, cmd_valid_b;
    logic       rdy, rv;
    logic [7:0] rd;
    logic [2:0] ss_sel;

    logic [63:0] stream_a = 64'h3C00_0000_0000_0000;
    logic [63:0] stream_b = 64'hFFEF_4000_0000_0000;
    int          idx_a = 64;
    int          idx_b = 64;
    logic [7:0]  mosi_cap_a = 8'h00;
    logic [23:0] mosi_cap_b = 24'h0;
    int          edges_a = 0;
    int          edges_b = 0;
    int          rsp_cnt_a = 0;
    int          ss_rise_b = 0;
    logic        in_burst = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    assign cmd_valid_a = cmd_valid & ~sel;
    assign cmd_valid_b = cmd_valid & sel;
    assign rdy    = sel ? cmd_ready_b : cmd_ready_a;
    assign rv     = sel ? rsp_valid_b : rsp_valid_a;
    assign rd     = sel ? rsp_data_b  : rsp_data_a;
    assign ss_sel = sel ? ss_n_b : {1'b1, ss_n_a};
    assign spi_miso_b = (&ss_n_b) ? 1'b1 : miso_b;

    always #5 clk = ~clk;

    spi_master_multi #(
        .NUM_SS(2), .DATA_W(8), .CLK_DIV(2),
        .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)
    ) u_dut_a (
        .clk_in_clk    (clk),
        .reset_reset_n (rst_n),
        .cmd_valid     (cmd_valid_a),
        .cmd_ready     (cmd_ready_a),
        .cmd_data      (cmd_data),
        .cmd_ss        (cmd_ss[0:0]),
        .cmd_last      (cmd_last),
        .rsp_valid     (rsp_valid_a),
        .rsp_data      (rsp_data_a),
        .spi_SCLK      (sclk_a),
        .spi_MOSI      (mosi_a),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback      (lb),
`endif
        .spi_MISO      (miso_a),
        .spi_SS_n      (ss_n_a)
    );

    spi_master_multi #(
        .NUM_SS(3), .DATA_W(8), .CLK_DIV(2),
        .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)
    ) u_dut_b (
        .clk_in_clk    (clk),
        .reset_reset_n (rst_n),
        .cmd_valid     (cmd_valid_b),
        .cmd_ready     (cmd_ready_b),
        .cmd_data      (cmd_data),
        .cmd_ss        (cmd_ss),
        .cmd_last      (cmd_last),
        .rsp_valid     (rsp_valid_b),
        .rsp_data      (rsp_data_b),
        .spi_SCLK      (sclk_b),
        .spi_MOSI      (mosi_b),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback      (1'b0),
`endif
        .spi_MISO      (spi_miso_b),
        .spi_SS_n      (ss_n_b)
    );

    // Mode 0 slave on A (slave 1): first bit at select, next bit on falling SCLK.
    always @(negedge ss_n_a[1]) begin
        miso_a = stream_a[63];
        idx_a  = 1;
    end
    always @(negedge sclk_a) begin
        if (idx_a < 64) begin
            miso_a = stream_a[63 - idx_a];
            idx_a++;
        end
    end

    // Mode 3 flash on B (slave 0): continuous stream across the held burst.
    always @(negedge ss_n_b[0]) idx_b = 0;
    always @(negedge sclk_b) begin
        if (idx_b < 64) begin
            miso_b = stream_b[63 - idx_b];
            idx_b++;
        end
    end

    always @(posedge sclk_a) mosi_cap_a = {mosi_cap_a[6:0], mosi_a};
    always @(posedge sclk_b) mosi_cap_b = {mosi_cap_b[22:0], mosi_b};
    always @(sclk_a) edges_a++;
    always @(sclk_b) edges_b++;
    always @(posedge clk) if (rsp_valid_a) rsp_cnt_a++;
    always @(posedge ss_n_b[0]) if (in_burst) ss_rise_b++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic s, input logic [7:0] d, input logic [1:0] ss,
                        input logic last, output logic [7:0] rx, output int lat,
                        output logic [2:0] ss_mid);
        int  n;
        time t_acc;
        sel = s;
        n = 0;
        while (!rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_wait", rdy, 1);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_ss    = ss;
        cmd_last  = last;
        @(posedge clk);
        t_acc = $time;
        #1;
        cmd_valid = 1'b0;
        cmd_data  = ~d;
        cmd_ss    = ~ss;
        cmd_last  = ~last;
        ss_mid    = ss_sel;
        n = 0;
        while (!rv && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rsp_wait", rv, 1);
        rx  = rd;
        lat = int'(($time - t_acc - 1) / 10);
    endtask

    initial begin
        logic [7:0] rx;
        int         lat;
        logic [2:0] ssm;
        int         e0, r0, n;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ss_a",    ss_n_a, 2'b11);
        check_eq("rst_ss_b",    ss_n_b, 3'b111);
        check_eq("rst_sclk_a",  sclk_a, 0);
        check_eq("rst_sclk_b",  sclk_b, 1);
        check_eq("rst_mosi_a",  mosi_a, 0);
        check_eq("rst_rv_a",    rsp_valid_a, 0);
        check_eq("rst_rd_a",    rsp_data_a, 8'h00);
        rst_n = 1'b1;
        check_eq("rst_rdy_low", cmd_ready_a, 0);
        @(posedge clk); #1;
        check_eq("rst_rdy_a",   cmd_ready_a, 1);
        check_eq("rst_rdy_b",   cmd_ready_b, 1);

        // Mode 0 single word to slave 1
        send(1'b0, 8'hA5, 2'd1, 1'b1, rx, lat, ssm);
        check_eq("m0_rx",   rx, 8'h3C);
        check_eq("m0_lat",  lat, 34);
        check_eq("m0_ss",   ssm, 3'b101);
        check_eq("m0_mosi", mosi_cap_a, 8'hA5);
        check_eq("m0_ss_release", ss_n_a, 2'b11);
        check_eq("m0_rdy_at_rsp", cmd_ready_a, 0);
        @(posedge clk); #1;
        check_eq("m0_rv_pulse", rsp_valid_a, 0);
        check_eq("m0_rd_hold",  rsp_data_a, 8'h3C);
        check_eq("m0_gap1",     cmd_ready_a, 0);
        @(posedge clk); #1;
        check_eq("m0_gap2",     cmd_ready_a, 1);

        // Mode 3 three-word burst to slave 0
        in_burst = 1'b1;
        send(1'b1, 8'h9F, 2'd0, 1'b0, rx, lat, ssm);
        check_eq("m3_lat1", lat, 34);
        check_eq("m3_ss1",  ssm, 3'b110);
        send(1'b1, 8'h00, 2'd2, 1'b0, rx, lat, ssm);
        check_eq("m3_rx2",  rx, 8'hEF);
        check_eq("m3_lat2", lat, 32);
        check_eq("m3_ss2",  ssm, 3'b110);
        send(1'b1, 8'h00, 2'd1, 1'b1, rx, lat, ssm);
        check_eq("m3_rx3",  rx, 8'h40);
        check_eq("m3_lat3", lat, 32);
        check_eq("m3_ss3",  ssm, 3'b110);
        check_eq("m3_ss_rises", ss_rise_b, 1);
        check_eq("m3_mosi", mosi_cap_b, 24'h9F0000);
        in_burst = 1'b0;

        // Out-of-range slave index on the 3-slave instance
        e0 = edges_b;
        send(1'b1, 8'h66, 2'd3, 1'b1, rx, lat, ssm);
        check_eq("oor_edges", edges_b - e0, 16);
        check_eq("oor_ss",    ssm, 3'b111);
        check_eq("oor_rx",    rx, 8'hFF);
        check_eq("oor_lat",   lat, 34);

        // Reset mid-transfer on A
        sel = 1'b0;
        n = 0;
        while (!cmd_ready_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b1;
        cmd_data  = 8'hA5;
        cmd_ss    = 2'd1;
        cmd_last  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        e0 = edges_a;
        n = 0;
        while ((edges_a - e0) < 7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("mid_edges", edges_a - e0, 7);
        r0 = rsp_cnt_a;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_ss",   ss_n_a, 2'b11);
        check_eq("mid_sclk", sclk_a, 0);
        check_eq("mid_rdy",  cmd_ready_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_eq("mid_no_rsp", rsp_cnt_a - r0, 0);
        send(1'b0, 8'hA5, 2'd1, 1'b1, rx, lat, ssm);
        check_eq("post_rx",  rx, 8'h3C);
        check_eq("post_lat", lat, 34);
        check_eq("post_ss",  ssm, 3'b101);

`ifdef SPI_MASTER_LOOPBACK_EN
        lb = 1'b1;
        send(1'b0, 8'h5A, 2'd1, 1'b1, rx, lat, ssm);
        check_eq("lb_rx", rx, 8'h5A);
        check_eq("lb_ss", ssm, 3'b111);
        lb = 1'b0;
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
